cmd_parser: RTL and testbench

Host-command front end for the command/Wishbone path. Consumes the raw host byte stream, decodes a 6-byte command header into a memory request on the mreq interface of `cmd_wb`, then forwards exactly the write-payload bytes to `cmd_wb`'s rx stream. It returns to header hunting once `cmd_wb` completes the request. It sits directly upstream of `cmd_wb` and owns the host rx stream.

---
 rtl/cmd_parser_pkg.sv | 35 +++
 rtl/cmd_parser.sv | 161 ++++++++++++++++
 tb/tb_cmd_parser.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_parser_pkg.sv
// cmd_parser_pkg: shared definitions for the host command parser.
//   - CMD_WSIZE_* word size codes carried in the opcode byte
//   - opcode bit positions and header length
//   - wsize_bytes(): word size code -> bytes per word (0 = illegal code)
//   - state_t: parser FSM state, also exported on the debug port
package cmd_parser_pkg;

   localparam logic [1:0] CMD_WSIZE_1BYTE = 2'd0;
   localparam logic [1:0] CMD_WSIZE_2BYTE = 2'd1;
   localparam logic [1:0] CMD_WSIZE_4BYTE = 2'd2;

   localparam int CMD_HDR_LEN   = 6;
   localparam int OP_WR_BIT     = 7;
   localparam int OP_AINCR_BIT  = 6;
   localparam int OP_RSVD_HI    = 5;
   localparam int OP_RSVD_LO    = 2;

   typedef enum logic [1:0] {
      ST_HDR   = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   function automatic logic [2:0] wsize_bytes(input logic [1:0] wsize);
      logic [2:0] b;
      case (wsize)
         CMD_WSIZE_1BYTE: b = 3'd1;
         CMD_WSIZE_2BYTE: b = 3'd2;
         CMD_WSIZE_4BYTE: b = 3'd4;
         default:         b = 3'd0;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/cmd_parser.sv
// cmd_parser: host command front end.
// Hunts for a 6-byte header (opcode, size, 32-bit little-endian address),
// presents it as a memory request on mreq, then passes exactly the write
// payload bytes through to the downstream rx stream.
//
// Ports
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_in_data/valid,
//   o_in_ready             host byte stream (consumed)
//   o_pl_data/valid,
//   i_pl_ready             payload stream to cmd_wb rx
//   o_mreq_*               memory request (valid held until i_mreq_ready)
//   o_err                  one-cycle protocol error pulse
//   dbg_state              current FSM state (debug only)
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; valid never waits on ready, ready may depend on valid's
// partner only through the combinational payload pass-through.
module cmd_parser
   import cmd_parser_pkg::*;
#(
   parameter int HDR_TIMEOUT = 65535
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_in_data,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   output logic [7:0]  o_pl_data,
   output logic        o_pl_valid,
   input  logic        i_pl_ready,
   output logic        o_mreq_valid,
   input  logic        i_mreq_ready,
   output logic        o_mreq_wr,
   output logic [1:0]  o_mreq_wsize,
   output logic        o_mreq_aincr,
   output logic [7:0]  o_mreq_size,
   output logic [31:0] o_mreq_addr,
   output logic        o_err,
   output state_t      dbg_state
);

   localparam int IW = (HDR_TIMEOUT > 1) ? $clog2(HDR_TIMEOUT + 1) : 1;
   // The idle counter holds k-1 during the k-th idle cycle, so the timeout
   // fires at the edge that ends idle cycle HDR_TIMEOUT.
   localparam logic [IW-1:0] TMO_LAST = IW'((HDR_TIMEOUT > 0) ? HDR_TIMEOUT - 1 : 0);

   state_t        state;
   logic [2:0]    idx;
   logic [9:0]    remaining;
   logic [9:0]    rem_next;
   logic [9:0]    wr_bytes;
   logic [IW-1:0] idle;
   logic          err_q;
   logic          in_ready;
   logic          pl_valid;
   logic          accept;
   logic          op_bad;

   always_comb begin
      in_ready = 1'b0;
      pl_valid = 1'b0;
      case (state)
         ST_HDR:   in_ready = 1'b1;
         ST_ISSUE: begin
            // Zero-latency pass-through; closes once the payload is used up
            // so the next header cannot leak downstream.
            in_ready = i_pl_ready && (remaining != 10'd0);
            pl_valid = i_in_valid && (remaining != 10'd0);
         end
         ST_DRAIN: in_ready = 1'b1;
         default:  in_ready = 1'b0;
      endcase
   end

   assign accept   = i_in_valid && in_ready;
   assign rem_next = remaining - 10'(accept);
   assign op_bad   = (i_in_data[OP_RSVD_HI:OP_RSVD_LO] != '0) ||
                     (wsize_bytes(i_in_data[1:0]) == 3'd0);
   // Opcode and size are already latched when the last address byte lands.
   assign wr_bytes = o_mreq_wr ? 10'(o_mreq_size) * 10'(wsize_bytes(o_mreq_wsize)) : 10'd0;

   assign o_in_ready   = in_ready;
   assign o_pl_valid   = pl_valid;
   assign o_pl_data    = i_in_data;
   assign o_mreq_valid = (state == ST_ISSUE);
   assign o_err        = err_q;
   assign dbg_state    = state;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= ST_HDR;
         idx          <= 3'd0;
         remaining    <= 10'd0;
         idle         <= '0;
         err_q        <= 1'b0;
         o_mreq_wr    <= 1'b0;
         o_mreq_aincr <= 1'b0;
         o_mreq_wsize <= 2'd0;
         o_mreq_size  <= 8'd0;
         o_mreq_addr  <= 32'd0;
      end else begin
         err_q <= 1'b0;
         case (state)
            ST_HDR: begin
               if (accept) begin
                  idle <= '0;
                  case (idx)
                     3'd0: begin
                        if (op_bad) begin
                           err_q <= 1'b1;  // byte dropped, keep hunting at B0
                        end else begin
                           o_mreq_wr    <= i_in_data[OP_WR_BIT];
                           o_mreq_aincr <= i_in_data[OP_AINCR_BIT];
                           o_mreq_wsize <= i_in_data[1:0];
                           idx          <= 3'd1;
                        end
                     end
                     3'd1: begin o_mreq_size        <= i_in_data; idx <= 3'd2; end
                     3'd2: begin o_mreq_addr[7:0]   <= i_in_data; idx <= 3'd3; end
                     3'd3: begin o_mreq_addr[15:8]  <= i_in_data; idx <= 3'd4; end
                     3'd4: begin o_mreq_addr[23:16] <= i_in_data; idx <= 3'd5; end
                     default: begin
                        o_mreq_addr[31:24] <= i_in_data;
                        idx                <= 3'd0;
                        remaining          <= wr_bytes;
                        state              <= ST_ISSUE;
                     end
                  endcase
               end else if (idx == 3'd0 || HDR_TIMEOUT == 0) begin
                  idle <= '0;
               end else if (idle == TMO_LAST) begin
                  idle  <= '0;
                  idx   <= 3'd0;
                  err_q <= 1'b1;
               end else begin
                  idle <= idle + IW'(1);
               end
            end
            ST_ISSUE: begin
               remaining <= rem_next;
               if (i_mreq_ready) begin
                  // Last payload byte in the same cycle as completion is fine.
                  if (rem_next == 10'd0) begin
                     state <= ST_HDR;
                  end else begin
                     err_q <= 1'b1;
                     state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               remaining <= rem_next;
               if (rem_next == 10'd0) state <= ST_HDR;
            end
            default: state <= ST_HDR;
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_parser.sv
// tb_cmd_parser: directed and randomized checks of cmd_parser against a
// transaction-level model (expected requests, payload bytes, error count).
module tb_cmd_parser;
   import cmd_parser_pkg::*;

   localparam int TMO = 8;

   typedef struct packed {
      logic        wr;
      logic        aincr;
      logic [1:0]  wsize;
      logic [7:0]  size;
      logic [31:0] addr;
   } req_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  i_in_data;
   logic        i_in_valid;
   logic        o_in_ready;
   logic [7:0]  o_pl_data;
   logic        o_pl_valid;
   logic        i_pl_ready;
   logic        o_mreq_valid;
   logic        i_mreq_ready;
   logic        o_mreq_wr;
   logic [1:0]  o_mreq_wsize;
   logic        o_mreq_aincr;
   logic [7:0]  o_mreq_size;
   logic [31:0] o_mreq_addr;
   logic        o_err;
   state_t      dbg_state;

   cmd_parser #(.HDR_TIMEOUT(TMO)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_in_data(i_in_data), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
      .o_pl_data(o_pl_data), .o_pl_valid(o_pl_valid), .i_pl_ready(i_pl_ready),
      .o_mreq_valid(o_mreq_valid), .i_mreq_ready(i_mreq_ready),
      .o_mreq_wr(o_mreq_wr), .o_mreq_wsize(o_mreq_wsize), .o_mreq_aincr(o_mreq_aincr),
      .o_mreq_size(o_mreq_size), .o_mreq_addr(o_mreq_addr),
      .o_err(o_err), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];
   req_t       exp_req_q[$];
   int         exp_err = 0;
   int         got_err = 0;
   int         fwd_cnt = 0;
   logic       prev_err = 1'b0;
   req_t       last_req;

   bit   rand_ready = 1'b0;
   logic pl_force   = 1'b1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Downstream rx ready: random backpressure or a fixed level.
   always @(posedge clk) begin
      #1;
      i_pl_ready = rand_ready ? ($urandom_range(0, 3) != 0) : pl_force;
   end

   // Compare process: every handshake and error pulse checked against model.
   always @(negedge clk) begin
      if (!rst) begin
         if (o_pl_valid && i_pl_ready) begin
            fwd_cnt++;
            if (exp_q.size() == 0) check("pl_unexpected", 64'(exp_q.size()), 64'd1);
            else check("pl_data", 64'(o_pl_data), 64'(exp_q.pop_front()));
         end
         if (o_mreq_valid && i_mreq_ready) begin
            if (exp_req_q.size() == 0) check("req_unexpected", 64'(exp_req_q.size()), 64'd1);
            else check("req_fields",
                       64'({o_mreq_wr, o_mreq_aincr, o_mreq_wsize, o_mreq_size, o_mreq_addr}),
                       64'(exp_req_q.pop_front()));
         end
         check("pl_outside_req", 64'(o_pl_valid && !o_mreq_valid), 64'd0);
         check("err_width", 64'(o_err && prev_err), 64'd0);
         if (o_err) got_err++;
         prev_err = o_err;
      end else begin
         prev_err = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      i_in_valid = 1'b1;
      i_in_data  = b;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         ok = o_in_ready;
         tick();
         if (ok) break;
      end
      i_in_valid = 1'b0;
      i_in_data  = 8'($urandom);
      if (!ok) check("send_timeout", 64'(ok), 64'd1);
   endtask

   function automatic logic [7:0] rand_good_op();
      logic [7:0] op;
      op      = 8'($urandom) & 8'hC0;
      op[1:0] = 2'($urandom_range(0, 2));
      return op;
   endfunction

   function automatic logic [7:0] rand_bad_op();
      logic [7:0] op;
      op = 8'($urandom);
      if (op[5:2] == 4'd0 && op[1:0] != 2'd3) op[3] = 1'b1;
      return op;
   endfunction

   task automatic send_hdr(input logic [7:0] b0, input logic [7:0] sz, input logic [31:0] addr);
      logic [7:0] hdr[6];
      hdr[0] = b0; hdr[1] = sz;
      for (int i = 0; i < 4; i++) hdr[2+i] = addr[8*i +: 8];
      for (int i = 0; i < 6; i++) begin
         send_byte(hdr[i]);
         if (rand_ready && i < 5) repeat ($urandom_range(0, 2)) tick();
      end
   endtask

   // One full command. early_after >= 0: complete the request after that many
   // payload bytes and drain the rest. same_cycle: last byte with completion.
   task automatic run_cmd(input logic [7:0] b0, input logic [7:0] sz, input logic [31:0] addr,
                          input int early_after, input bit same_cycle);
      req_t r;
      int   n;
      int   lim;
      r.wr = b0[7]; r.aincr = b0[6]; r.wsize = b0[1:0]; r.size = sz; r.addr = addr;
      n = r.wr ? int'(sz) * (1 << r.wsize) : 0;
      exp_req_q.push_back(r);
      send_hdr(b0, sz, addr);
      @(negedge clk);
      check("mreq_valid_rise", 64'(o_mreq_valid), 64'd1);
      last_req = {o_mreq_wr, o_mreq_aincr, o_mreq_wsize, o_mreq_size, o_mreq_addr};
      tick();
      lim = (early_after >= 0) ? early_after : n;
      for (int i = 0; i < lim; i++) begin
         logic [7:0] d;
         d = 8'($urandom);
         exp_q.push_back(d);
         if (same_cycle && i == n - 1) i_mreq_ready = 1'b1;
         send_byte(d);
         i_mreq_ready = 1'b0;
      end
      if (early_after >= 0) begin
         i_mreq_ready = 1'b1;
         tick();
         i_mreq_ready = 1'b0;
         exp_err++;
         for (int i = early_after; i < n; i++) begin
            i_in_valid = 1'b1;
            i_in_data  = 8'($urandom);
            @(negedge clk);
            check("drain_pl_valid", 64'(o_pl_valid), 64'd0);
            check("drain_in_ready", 64'(o_in_ready), 64'd1);
            tick();
         end
         i_in_valid = 1'b0;
      end else if (!same_cycle) begin
         i_in_valid = 1'b1;
         i_in_data  = 8'($urandom);
         repeat ($urandom_range(1, 3)) begin
            @(negedge clk);
            check("no_leak_ready", 64'(o_in_ready), 64'd0);
            check("no_leak_pl", 64'(o_pl_valid), 64'd0);
            check("mreq_hold", 64'(o_mreq_valid), 64'd1);
            tick();
         end
         i_in_valid   = 1'b0;
         i_mreq_ready = 1'b1;
         tick();
         i_mreq_ready = 1'b0;
      end
      @(negedge clk);
      check("mreq_drop", 64'(o_mreq_valid), 64'd0);
      check("hdr_ready", 64'(o_in_ready), 64'd1);
      check("err_count", 64'(got_err), 64'(exp_err));
      tick();
   endtask

   task automatic partial_timeout(input int nbytes, input bit per_cycle);
      send_byte(rand_good_op());
      for (int i = 1; i < nbytes; i++) send_byte(8'($urandom));
      for (int k = 1; k <= TMO; k++) begin
         if (per_cycle) begin
            @(negedge clk);
            check("tmo_quiet", 64'(o_err), 64'd0);
         end
         tick();
      end
      @(negedge clk);
      check("tmo_err", 64'(o_err), 64'd1);
      tick();
      exp_err++;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int f0;
      rst = 1'b1; i_in_valid = 1'b0; i_in_data = 8'd0; i_mreq_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_mreq_valid", 64'(o_mreq_valid), 64'd0);
      check("rst_pl_valid", 64'(o_pl_valid), 64'd0);
      check("rst_err", 64'(o_err), 64'd0);
      check("rst_fields", 64'({o_mreq_wr, o_mreq_aincr, o_mreq_wsize, o_mreq_size, o_mreq_addr}), 64'd0);
      check("rst_in_ready", 64'(o_in_ready), 64'd1);
      tick();

      // Write: wsize 2B, aincr, size 2, addr 0x0C -> 4 payload bytes.
      f0 = fwd_cnt;
      run_cmd(8'hC0 | 8'(CMD_WSIZE_2BYTE), 8'd2, 32'h0000_000C, -1, 1'b0);
      check("t1_req", 64'(last_req), 64'({1'b1, 1'b1, CMD_WSIZE_2BYTE, 8'd2, 32'h0C}));
      check("t1_fwd", 64'(fwd_cnt - f0), 64'd4);

      // Read: no payload, nothing accepted while the request is pending.
      f0 = fwd_cnt;
      run_cmd(8'(CMD_WSIZE_4BYTE), 8'd1, 32'h0000_0010, -1, 1'b0);
      check("t2_req", 64'(last_req), 64'({1'b0, 1'b0, CMD_WSIZE_4BYTE, 8'd1, 32'h10}));
      check("t2_fwd", 64'(fwd_cnt - f0), 64'd0);

      // Reserved opcode bit, then a valid header.
      send_byte(8'h04);
      exp_err++;
      @(negedge clk);
      check("bad_op_err", 64'(o_err), 64'd1);
      check("bad_op_state", 64'(dbg_state), 64'(ST_HDR));
      tick();
      run_cmd(8'h80 | 8'(CMD_WSIZE_1BYTE), 8'd3, 32'hDEAD_BEEF, -1, 1'b0);
      check("t3_req", 64'(last_req), 64'({1'b1, 1'b0, CMD_WSIZE_1BYTE, 8'd3, 32'hDEADBEEF}));

      // Partial header timeout, then a fresh header.
      partial_timeout(3, 1'b1);
      run_cmd(8'h40 | 8'(CMD_WSIZE_2BYTE), 8'd7, 32'h1234_5678, -1, 1'b0);
      check("t4_req", 64'(last_req), 64'({1'b0, 1'b1, CMD_WSIZE_2BYTE, 8'd7, 32'h12345678}));

      // Early completion after 5 of 8 bytes: error and 3-byte drain.
      f0 = fwd_cnt;
      run_cmd(8'h80 | 8'(CMD_WSIZE_4BYTE), 8'd2, 32'h0000_0100, 5, 1'b0);
      check("t5_fwd", 64'(fwd_cnt - f0), 64'd5);

      // Last payload byte together with completion is not an error.
      run_cmd(8'h80 | 8'(CMD_WSIZE_1BYTE), 8'd4, 32'h0000_0200, -1, 1'b1);

      // size 0 write: request issued, no payload.
      f0 = fwd_cnt;
      run_cmd(8'hC0 | 8'(CMD_WSIZE_4BYTE), 8'd0, 32'h0000_0300, -1, 1'b0);
      check("t7_fwd", 64'(fwd_cnt - f0), 64'd0);

      // Reset in the middle of a payload.
      send_hdr(8'h80 | 8'(CMD_WSIZE_2BYTE), 8'd10, 32'h0000_0400);
      for (int i = 0; i < 3; i++) begin
         logic [7:0] d;
         d = 8'($urandom);
         exp_q.push_back(d);
         send_byte(d);
      end
      i_in_valid = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      i_in_valid = 1'b0;
      exp_q.delete();
      exp_req_q.delete();
      @(negedge clk);
      check("mid_rst_mreq_valid", 64'(o_mreq_valid), 64'd0);
      check("mid_rst_pl_valid", 64'(o_pl_valid), 64'd0);
      check("mid_rst_err", 64'(o_err), 64'd0);
      check("mid_rst_fields", 64'({o_mreq_wr, o_mreq_aincr, o_mreq_wsize, o_mreq_size, o_mreq_addr}), 64'd0);
      check("mid_rst_in_ready", 64'(o_in_ready), 64'd1);
      tick();
      run_cmd(8'h80 | 8'(CMD_WSIZE_1BYTE), 8'd2, 32'h0000_0500, -1, 1'b0);
      check("t8_req", 64'(last_req), 64'({1'b1, 1'b0, CMD_WSIZE_1BYTE, 8'd2, 32'h500}));

      // Randomized traffic with downstream backpressure.
      rand_ready = 1'b1;
      for (int t = 0; t < 40; t++) begin
         int sel;
         sel = $urandom_range(0, 9);
         if (sel == 0) begin
            send_byte(rand_bad_op());
            exp_err++;
         end else if (sel == 1) begin
            partial_timeout($urandom_range(1, 5), 1'b0);
         end
         run_cmd(rand_good_op(), 8'($urandom_range(0, 16)), $urandom, -1, 1'b0);
      end
      rand_ready = 1'b0;

      repeat (4) tick();
      check("payload_q_empty", 64'(exp_q.size()), 64'd0);
      check("req_q_empty", 64'(exp_req_q.size()), 64'd0);
      check("final_err_count", 64'(got_err), 64'(exp_err));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
